crypto_bus_xfer: RTL and testbench

Transfer sequencer between the system data bus and the cryptographic core's bank of 16-bit data registers. It drives each register's bus-side save/send strobes. A LOAD command streams NUM_REGS words from the bus into registers 0..NUM_REGS-1. A STORE command reads the registers back, in index order, onto the bus through a valid/ready output. It sits directly upstream and downstream of the data-register bank, on its bus-facing side.

---
 rtl/crypto_core_pkg.sv | 24 ++
 rtl/crypto_idx_decoder.sv | 21 ++
 rtl/crypto_bus_xfer.sv | 148 ++++++++++++++
 tb/tb_crypto_bus_xfer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crypto_core_pkg
//  Description : Shared types and constants for the crypto core bus-side logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package crypto_core_pkg;

    localparam int DEFAULT_DATA_W = 16;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_RD_OUT = 3'd4,
        ST_DONE   = 3'd5
    } xfer_state_t;

endpackage : crypto_core_pkg
`default_nettype wire

// File: rtl/crypto_idx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : crypto_idx_decoder
//  Description : Register index to one-hot strobe decoder with enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module crypto_idx_decoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_idx,
    output logic [N-1:0]     o_onehot
);

    for (genvar g = 0; g < N; g++) begin : g_bit
        assign o_onehot[g] = i_en && (i_idx == IDX_W'(g));
    end

endmodule : crypto_idx_decoder
`default_nettype wire

// File: rtl/crypto_bus_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : crypto_bus_xfer
//  Description : Bus <-> data-register-bank transfer sequencer (LOAD / STORE).
//  Revision    : 1.0 - initial release
// ============================================================================
module crypto_bus_xfer
    import crypto_core_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DEFAULT_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic                       cmd_op,
    output logic                       cmd_ready,
    input  logic                       core_busy,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_REGS-1:0]        reg_save_bus,
    output logic [DATA_W-1:0]          reg_wdata,
    output logic [NUM_REGS-1:0]        reg_send_bus,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    output logic                       done
);

    localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REGS - 1);

    xfer_state_t       r_state;
    xfer_state_t       w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;

    logic              w_cmd_ready;
    logic              w_save_en;
    logic              w_send_en;
    logic              w_last;
    logic [DATA_W-1:0] w_rdata_sel;

    assign w_cmd_ready = (r_state == ST_IDLE) && !core_busy;
    // Save strobe only ever fires alongside a valid bus word.
    assign w_save_en   = (r_state == ST_LOAD) && in_valid;
    assign w_send_en   = (r_state == ST_RD_REQ);
    assign w_last      = (r_idx == C_LAST_IDX);
    assign w_rdata_sel = reg_rdata[int'(r_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (cmd_op == CMD_LOAD) ? ST_LOAD : ST_RD_REQ;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_RD_REQ: begin
                w_state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                // Register send output was refreshed by last cycle's strobe.
                w_out_data_nxt  = w_rdata_sel;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    crypto_idx_decoder #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_save_dec (
        .i_en     (w_save_en),
        .i_idx    (r_idx),
        .o_onehot (reg_save_bus)
    );

    crypto_idx_decoder #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_send_dec (
        .i_en     (w_send_en),
        .i_idx    (r_idx),
        .o_onehot (reg_send_bus)
    );

    assign cmd_ready = w_cmd_ready;
    assign in_ready  = (r_state == ST_LOAD);
    assign reg_wdata = w_save_en ? in_data : '0;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = (r_state == ST_DONE);

endmodule : crypto_bus_xfer
`default_nettype wire

// File: tb/tb_crypto_bus_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crypto_bus_xfer
//  Description : Self-checking bench for crypto_bus_xfer with a register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crypto_bus_xfer;

    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       cmd_valid;
    logic                       cmd_op;
    logic                       cmd_ready;
    logic                       core_busy;
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_REGS-1:0]        reg_save_bus;
    logic [DATA_W-1:0]          reg_wdata;
    logic [NUM_REGS-1:0]        reg_send_bus;
    logic [NUM_REGS*DATA_W-1:0] reg_rdata;
    logic                       done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected register contents, as implied by the words driven so far.
    logic [DATA_W-1:0] exp_reg [NUM_REGS];
    logic [DATA_W-1:0] ld_data [NUM_REGS];
    int                ld_gap  [NUM_REGS];

    // Register bank: bus-side save writes, bus-side send refreshes the output.
    logic [DATA_W-1:0] bank   [NUM_REGS];
    logic [DATA_W-1:0] send_q [NUM_REGS];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_save_bus[i]) bank[i] <= reg_wdata;
            if (reg_send_bus[i]) send_q[i] <= bank[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rdata
        assign reg_rdata[g*DATA_W +: DATA_W] = send_q[g];
    end

    crypto_bus_xfer #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .core_busy    (core_busy),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reg_save_bus (reg_save_bus),
        .reg_wdata    (reg_wdata),
        .reg_send_bus (reg_send_bus),
        .reg_rdata    (reg_rdata),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),     0);
        chk({tag, "_out_valid"}, 32'(out_valid),    0);
        chk({tag, "_out_data"},  32'(out_data),     0);
        chk({tag, "_save"},      32'(reg_save_bus), 0);
        chk({tag, "_send"},      32'(reg_send_bus), 0);
        chk({tag, "_done"},      32'(done),         0);
    endtask

    // LOAD of ld_data[] with ld_gap[k] idle cycles before word k.
    task automatic do_load(input int busy);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        for (int b = 0; b < busy; b++) begin
            core_busy = 1'b1;
            #1;
            chk("busy_cmd_ready", 32'(cmd_ready), 0);
            chk("busy_no_activity", {in_ready, reg_save_bus, reg_send_bus, done}, 0);
            tick;
        end
        core_busy = 1'b0;
        #1;
        chk("load_cmd_ready", 32'(cmd_ready), 1);
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            for (int g = 0; g < ld_gap[k]; g++) begin
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
                #1;
                chk("gap_in_ready", 32'(in_ready), 1);
                chk("gap_no_strobe", 32'(reg_save_bus), 0);
                tick;
            end
            in_valid = 1'b1;
            in_data  = ld_data[k];
            #1;
            chk("load_in_ready", 32'(in_ready), 1);
            chk("load_save_bus", 32'(reg_save_bus), 32'(1) << k);
            chk("load_wdata", 32'(reg_wdata), 32'(ld_data[k]));
            chk("load_no_send", 32'(reg_send_bus), 0);
            tick;
            exp_reg[k] = ld_data[k];
        end
        in_valid = 1'b0;
        #1;
        chk("load_done", 32'(done), 1);
        chk("load_done_in_ready", 32'(in_ready), 0);
        chk("load_done_save", 32'(reg_save_bus), 0);
        tick;
        #1;
        chk("load_done_pulse", 32'(done), 0);
        chk("load_idle_ready", 32'(cmd_ready), 1);
    endtask

    // STORE; optional forced stall on one word and optional random backpressure.
    task automatic do_store(input int stall_word, input int stall_len, input bit rnd);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        #1;
        chk("store_cmd_ready", 32'(cmd_ready), 1);
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            int sends   = 0;
            int stalled = 0;
            int t       = 0;
            bit hs      = 1'b0;
            while (!hs && t < 40) begin
                if (out_valid && k == stall_word && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else if (out_valid && rnd && $urandom_range(0, 2) == 0) begin
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
                #1;
                chk("store_no_save", 32'(reg_save_bus), 0);
                if (reg_send_bus != '0) begin
                    sends++;
                    chk("store_send_onehot", 32'(reg_send_bus), 32'(1) << k);
                    chk("store_send_no_valid", 32'(out_valid), 0);
                end
                if (out_valid) chk("store_out_data", 32'(out_data), 32'(exp_reg[k]));
                hs = out_valid && out_ready;
                tick;
                t++;
            end
            chk("store_handshake", 32'(hs), 1);
            chk("store_sends_per_word", 32'(sends), 1);
            if (k == stall_word) chk("store_stall_len", 32'(stalled), 32'(stall_len));
        end
        out_ready = 1'b0;
        #1;
        chk("store_done", 32'(done), 1);
        chk("store_done_out_valid", 32'(out_valid), 0);
        tick;
        #1;
        chk("store_done_pulse", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        core_busy = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        repeat (3) tick;
        chk_quiet("reset");
        rst = 1'b0;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        tick;

        // Back-to-back LOAD.
        ld_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        ld_gap  = '{0, 0, 0, 0};
        do_load(0);

        // Gapped LOAD with random words.
        for (int k = 0; k < NUM_REGS; k++) ld_data[k] = DATA_W'($urandom);
        ld_gap = '{0, 3, 3, 3};
        do_load(0);

        // Preload and STORE with sink always ready.
        ld_data = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
        ld_gap  = '{0, 0, 0, 0};
        do_load(0);
        do_store(-1, 0, 1'b0);

        // STORE with word 2 stalled five cycles.
        do_store(2, 5, 1'b0);

        // core_busy blocks acceptance, then LOAD proceeds.
        for (int k = 0; k < NUM_REGS; k++) ld_data[k] = DATA_W'($urandom);
        do_load(3);
        do_store(-1, 0, 1'b0);

        // Random LOAD / STORE rounds.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                ld_data[k] = DATA_W'($urandom);
                ld_gap[k]  = int'($urandom_range(0, 2));
            end
            do_load(int'($urandom_range(0, 2)));
            do_store(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, 4)), 1'b1);
        end

        // Reset after two LOAD words: no rollback of written registers.
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            #1;
            chk("rst_load_save_bus", 32'(reg_save_bus), 32'(1) << k);
            exp_reg[k] = in_data;
            tick;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk_quiet("mid_reset");
        chk("mid_reset_idle", 32'(cmd_ready), 1);
        tick;
        do_store(-1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_crypto_bus_xfer
`default_nettype wire
